dram_req_scheduler: RTL and testbench

Shares the single DRAM command path among NUM_REQ requesters (e.g. DMA, scratchpad fill, host). Selects one request at a time with row-hit-first, round-robin-fallback priority and hands it to the command FSM. Tracks the open row per bank and gates new issues while refresh is pending. Sits between the requester ports and the command FSM / timing control.

---
 rtl/dram_pkg.sv | 18 +
 rtl/rr_pick.sv | 30 +++
 rtl/dram_req_scheduler.sv | 160 ++++++++++++++++
 tb/tb_dram_req_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared address layout and scheduler state encoding for the DRAM request scheduler.
package dram_pkg;

  // Address layout: column in [12:0], bank in [15:13], row in [31:16]
  localparam int BANK_OFF  = 13;
  localparam int BANK_W    = 3;
  localparam int ROW_OFF   = 16;
  localparam int ROW_W     = 16;
  localparam int NUM_BANKS = 1 << BANK_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    BUSY    = 2'd2,
    REFRESH = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: lowest set bit of reqMask at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  reqMask,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grantOh,
  output logic [IW-1:0] grantIdx
);

  logic          found;
  logic [IW-1:0] j;

  always_comb begin
    grantOh  = '0;
    grantIdx = '0;
    found    = 1'b0;
    j        = '0;
    for (int i = 0; i < N; i++) begin
      j = IW'((int'(ptr) + i) % N);
      if (!found && reqMask[j]) begin
        found       = 1'b1;
        grantOh[j]  = 1'b1;
        grantIdx    = j;
      end
    end
  end

endmodule

// File: rtl/dram_req_scheduler.sv
// Row-hit-first / round-robin arbiter feeding the DRAM command FSM, with per-bank open-row tracking.
// Optional hit/miss counters are enabled with the DRAM_SCHED_STATS_EN macro.
module dram_req_scheduler
  import dram_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 32,
  parameter int MAX_HIT_STREAK = 4
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        cmd_valid,
  input  logic                        cmd_ready,
  output logic [ADDR_W-1:0]           cmd_addr,
  output logic                        cmd_write,
  output logic                        cmd_row_hit,
  output logic [$clog2(NUM_REQ)-1:0]  cmd_id,
  input  logic                        xfer_done,
  input  logic                        rf_req,
  input  logic                        tREF_done,
  output logic                        ref_hold
`ifdef DRAM_SCHED_STATS_EN
  ,
  output logic [31:0]                 stat_hits,
  output logic [31:0]                 stat_misses
`endif
);

  localparam int IW = $clog2(NUM_REQ);

  sched_state_t        state, stateNext;
  logic [ADDR_W-1:0]   reqAddr [NUM_REQ];
  logic [NUM_REQ-1:0]  hitMask, hitOh, allOh, winOh;
  logic [IW-1:0]       hitIdx, allIdx, winIdx, rrPtr;
  logic [3:0]          streak;
  logic                useHit, pick, handshake, cmdBypass;
  logic                bankOpen [NUM_BANKS];
  logic [ROW_W-1:0]    bankRow  [NUM_BANKS];
  logic [BANK_W-1:0]   cmdBank;
  logic [ROW_W-1:0]    cmdRow;

  always_comb begin
    hitMask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      reqAddr[i] = req_addr[i*ADDR_W +: ADDR_W];
      hitMask[i] = req_valid[i] && bankOpen[reqAddr[i][BANK_OFF +: BANK_W]] &&
                   (bankRow[reqAddr[i][BANK_OFF +: BANK_W]] == reqAddr[i][ROW_OFF +: ROW_W]);
    end
  end

  rr_pick #(.N(NUM_REQ), .IW(IW)) uHitPick (
    .reqMask (hitMask),
    .ptr     (rrPtr),
    .grantOh (hitOh),
    .grantIdx(hitIdx)
  );

  rr_pick #(.N(NUM_REQ), .IW(IW)) uAllPick (
    .reqMask (req_valid),
    .ptr     (rrPtr),
    .grantOh (allOh),
    .grantIdx(allIdx)
  );

  // The hit bypass is only honoured while the streak budget lasts, so misses cannot starve
  assign useHit    = (|hitMask) && (streak < 4'(MAX_HIT_STREAK));
  assign winOh     = useHit ? hitOh : allOh;
  assign winIdx    = useHit ? hitIdx : allIdx;
  assign pick      = (state == IDLE) && !rf_req && (|req_valid);
  assign handshake = (state == ISSUE) && cmd_ready;
  assign cmdBank   = cmd_addr[BANK_OFF +: BANK_W];
  assign cmdRow    = cmd_addr[ROW_OFF +: ROW_W];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    cmd_valid = 1'b0;
    ref_hold  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rf_req)              stateNext = REFRESH;
        else if (|req_valid)     stateNext = ISSUE;
      end
      ISSUE: begin
        cmd_valid = 1'b1;
        if (cmd_ready) stateNext = BUSY;
      end
      BUSY: begin
        if (xfer_done) stateNext = IDLE;
      end
      REFRESH: begin
        ref_hold = 1'b1;
        if (tREF_done) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      req_ready   <= '0;
      cmd_addr    <= '0;
      cmd_write   <= 1'b0;
      cmd_row_hit <= 1'b0;
      cmd_id      <= '0;
      cmdBypass   <= 1'b0;
      rrPtr       <= '0;
      streak      <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        bankOpen[b] <= 1'b0;
        bankRow[b]  <= '0;
      end
    end else begin
      req_ready <= pick ? winOh : '0;
      if (pick) begin
        cmd_addr    <= reqAddr[winIdx];
        cmd_write   <= req_write[winIdx];
        cmd_row_hit <= hitMask[winIdx];
        cmd_id      <= winIdx;
        // A hit that round-robin would have chosen anyway does not consume streak budget
        cmdBypass   <= useHit && (hitIdx != allIdx);
      end
      if (handshake) begin
        bankOpen[cmdBank] <= 1'b1;
        bankRow[cmdBank]  <= cmdRow;
        rrPtr             <= (cmd_id == IW'(NUM_REQ - 1)) ? '0 : cmd_id + 1'b1;
        if (!cmdBypass)                           streak <= '0;
        else if (streak != 4'(MAX_HIT_STREAK))    streak <= streak + 4'd1;
      end
      if ((state == REFRESH) && tREF_done) begin
        streak <= '0;
        for (int b = 0; b < NUM_BANKS; b++) bankOpen[b] <= 1'b0;
      end
    end
  end

`ifdef DRAM_SCHED_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (handshake) begin
      if (cmd_row_hit) begin
        if (stat_hits != '1) stat_hits <= stat_hits + 32'd1;
      end else begin
        if (stat_misses != '1) stat_misses <= stat_misses + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dram_req_scheduler.sv
// Directed, table-driven bench for dram_req_scheduler (NUM_REQ=4, ADDR_W=32, MAX_HIT_STREAK=4).
module tb_dram_req_scheduler;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [3:0]  req_valid, req_write, req_ready;
  logic [127:0] req_addr;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_row_hit;
  logic [31:0] cmd_addr;
  logic [1:0]  cmd_id;
  logic        xfer_done, rf_req, tREF_done, ref_hold;
`ifdef DRAM_SCHED_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  dram_req_scheduler #(.NUM_REQ(4), .ADDR_W(32), .MAX_HIT_STREAK(4)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_write  (cmd_write),
    .cmd_row_hit(cmd_row_hit),
    .cmd_id     (cmd_id),
    .xfer_done  (xfer_done),
    .rf_req     (rf_req),
    .tREF_done  (tREF_done),
    .ref_hold   (ref_hold)
`ifdef DRAM_SCHED_STATS_EN
    ,
    .stat_hits  (stat_hits),
    .stat_misses(stat_misses)
`endif
  );

  typedef struct {
    logic [3:0]       valid;
    logic [3:0]       wr;
    logic [3:0][31:0] addr;
    logic [3:0]       expReady;
    logic [1:0]       expId;
    logic             expHit;
    int               stall;
  } vec_t;

  vec_t tbl [12];

  // bank in [15:13], row in [31:16]
  function automatic logic [31:0] mk(input int bank, input int row);
    return 32'((row << 16) | (bank << 13));
  endfunction

  function automatic vec_t mkVec(input logic [3:0] valid, input logic [3:0] wr,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] a2, input logic [31:0] a3,
                                 input logic [3:0] expReady, input logic [1:0] expId,
                                 input logic expHit, input int stall);
    vec_t v;
    v.valid = valid; v.wr = wr; v.addr = {a3, a2, a1, a0};
    v.expReady = expReady; v.expId = expId; v.expHit = expHit; v.stall = stall;
    return v;
  endfunction

  task automatic check(input string tag, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s/%s actual=%0h required=%0h", tag, name, act, exp);
    end
  endtask

  // Called just after a rising edge with the DUT idle; returns just after a rising edge, idle again.
  task automatic doTxn(input vec_t v, input string tag);
    int   lat;
    logic got;
    req_valid = v.valid; req_write = v.wr; req_addr = v.addr;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge CLK);
      lat++;
      if (req_ready != 4'b0) got = 1'b1;
    end
    check(tag, "granted", got, 1'b1);
    check(tag, "latency", lat, 2);
    check(tag, "req_ready", req_ready, v.expReady);
    check(tag, "cmd_id", cmd_id, v.expId);
    check(tag, "row_hit", cmd_row_hit, v.expHit);
    check(tag, "cmd_valid", cmd_valid, 1'b1);
    check(tag, "cmd_addr", cmd_addr, v.addr[v.expId]);
    check(tag, "cmd_write", cmd_write, v.wr[v.expId]);
    @(posedge CLK); #1;
    req_valid = v.valid & ~v.expReady;
    for (int k = 0; k < v.stall; k++) begin
      @(negedge CLK);
      check(tag, "stall_addr", cmd_addr, v.addr[v.expId]);
      check(tag, "stall_id", cmd_id, v.expId);
      check(tag, "stall_write", cmd_write, v.wr[v.expId]);
      check(tag, "stall_valid", cmd_valid, 1'b1);
      check(tag, "stall_ready", req_ready, 4'b0);
      xfer_done = (k == 1);
    end
    xfer_done = 1'b0;
    cmd_ready = 1'b1;
    @(posedge CLK); #1;
    cmd_ready = 1'b0;
    check(tag, "busy_valid", cmd_valid, 1'b0);
    check(tag, "busy_ready", req_ready, 4'b0);
    xfer_done = 1'b1;
    req_valid = 4'b0;
    @(posedge CLK); #1;
    xfer_done = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   lat;
    logic got;

    tbl[0]  = mkVec(4'b0110, 4'b0000, 0, mk(1,3), mk(2,4), 0, 4'b0010, 1, 0, 0);
    tbl[1]  = mkVec(4'b0100, 4'b0000, 0, 0, mk(2,4), 0, 4'b0100, 2, 0, 0);
    tbl[2]  = mkVec(4'b0001, 4'b0001, mk(0,5), 0, 0, 0, 4'b0001, 0, 0, 0);
    tbl[3]  = mkVec(4'b1010, 4'b0000, 0, mk(0,7), 0, mk(0,5), 4'b1000, 3, 1, 0);
    tbl[4]  = mkVec(4'b0010, 4'b0010, 0, mk(0,7), 0, 0, 4'b0010, 1, 0, 0);
    tbl[5]  = mkVec(4'b0001, 4'b0000, mk(3,9), 0, 0, 0, 4'b0001, 0, 0, 0);
    for (int i = 6; i < 10; i++)
      tbl[i] = mkVec(4'b0101, 4'b0000, mk(3,9), 0, mk(4,1), 0, 4'b0001, 0, 1, 0);
    tbl[10] = mkVec(4'b0101, 4'b0000, mk(3,9), 0, mk(4,1), 0, 4'b0100, 2, 0, 0);
    tbl[11] = mkVec(4'b0001, 4'b0000, mk(3,9), 0, 0, 0, 4'b0001, 0, 1, 0);

    nRST = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0;
    cmd_ready = 1'b0; xfer_done = 1'b0; rf_req = 1'b0; tREF_done = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset", "req_ready", req_ready, 4'b0);
    check("reset", "cmd_valid", cmd_valid, 1'b0);
    check("reset", "cmd_addr", cmd_addr, 32'h0);
    check("reset", "cmd_id", cmd_id, 2'd0);
    check("reset", "row_hit", cmd_row_hit, 1'b0);
    check("reset", "ref_hold", ref_hold, 1'b0);
    nRST = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 12; i++) doTxn(tbl[i], $sformatf("vec%0d", i));

    // Refresh wins over a same-cycle request and closes every bank
    rf_req = 1'b1;
    req_valid = 4'b0001; req_write = 4'b0; req_addr = {96'h0, mk(3,9)};
    @(posedge CLK);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check("refresh", "ref_hold", ref_hold, 1'b1);
      check("refresh", "req_ready", req_ready, 4'b0);
      check("refresh", "cmd_valid", cmd_valid, 1'b0);
    end
    @(posedge CLK); #1;
    tREF_done = 1'b1; rf_req = 1'b0;
    @(posedge CLK); #1;
    tREF_done = 1'b0;
    check("refresh", "hold_drop", ref_hold, 1'b0);
    doTxn(mkVec(4'b0001, 4'b0000, mk(3,9), 0, 0, 0, 4'b0001, 0, 0, 0), "postref");

    // Command stall with a second requester waiting
    doTxn(mkVec(4'b0011, 4'b0010, mk(3,9), mk(5,2), 0, 0, 4'b0001, 0, 1, 5), "stall");

    // Reset during BUSY
    req_valid = 4'b0100; req_write = 4'b0100; req_addr = {32'h0, mk(2,4), 64'h0};
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge CLK);
      lat++;
      if (req_ready != 4'b0) got = 1'b1;
    end
    check("rstbusy", "req_ready", req_ready, 4'b0100);
    @(posedge CLK); #1;
    req_valid = 4'b0; cmd_ready = 1'b1;
    @(posedge CLK); #1;
    cmd_ready = 1'b0;
    #2 nRST = 1'b0;
    #1;
    check("rstbusy", "req_ready", req_ready, 4'b0);
    check("rstbusy", "cmd_valid", cmd_valid, 1'b0);
    check("rstbusy", "cmd_addr", cmd_addr, 32'h0);
    check("rstbusy", "cmd_write", cmd_write, 1'b0);
    check("rstbusy", "cmd_id", cmd_id, 2'd0);
    check("rstbusy", "ref_hold", ref_hold, 1'b0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(posedge CLK); #1;
    v = mkVec(4'b1001, 4'b0000, mk(2,4), 0, 0, mk(6,6), 4'b0001, 0, 0, 0);
    doTxn(v, "postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
